// File: rtl/fpu_ss_pkg.sv
// fpu_ss_pkg: shared types for the FPU subsystem issue and writeback path.
package fpu_ss_pkg;
    localparam int NumFpRegs = 32;
    typedef logic [4:0] fpr_addr_t;
    typedef logic [3:0] xid_t;
    typedef struct packed {
        fpr_addr_t addr;
        logic      rd_is_fp;
        xid_t      id;
    } fpu_tag_t;
    typedef struct packed {
        xid_t      id;
        fpr_addr_t rd;
        logic      we;
    } mem_metadata_t;
endpackage

// File: rtl/fpu_ss_issue_ctrl_if.sv
// fpu_ss_issue_ctrl_if: decoder, fpnew, load path, regfile write port and x-if result signals.
interface fpu_ss_issue_ctrl_if;
    import fpu_ss_pkg::*;
    logic                issue_valid;
    logic                issue_ready;
    logic                issue_is_load;
    fpr_addr_t [2:0]     issue_rs_addr;
    logic [2:0]          issue_rs_fp;
    fpr_addr_t           issue_rd;
    logic                issue_rd_is_fp;
    xid_t                issue_id;
    logic                fpu_in_valid;
    logic                fpu_in_ready;
    fpu_tag_t            fpu_tag;
    logic                fpu_out_valid;
    fpu_tag_t            fpu_out_tag;
    logic                fpu_out_ready;
    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic                mem_res_valid;
    mem_metadata_t       mem_meta;
    logic                fpr_we;
    fpr_addr_t           fpr_waddr;
    logic                fpr_wsel;
    logic                xres_valid;
    logic                xres_ready;
    modport slave (
        input  issue_valid, issue_is_load, issue_rs_addr, issue_rs_fp, issue_rd, issue_rd_is_fp, issue_id,
        input  fpu_in_ready, fpu_out_valid, fpu_out_tag, lsu_req_ready, mem_res_valid, mem_meta, xres_ready,
        output issue_ready, fpu_in_valid, fpu_tag, fpu_out_ready, lsu_req_valid,
        output fpr_we, fpr_waddr, fpr_wsel, xres_valid
    );
    modport master (
        output issue_valid, issue_is_load, issue_rs_addr, issue_rs_fp, issue_rd, issue_rd_is_fp, issue_id,
        output fpu_in_ready, fpu_out_valid, fpu_out_tag, lsu_req_ready, mem_res_valid, mem_meta, xres_ready,
        input  issue_ready, fpu_in_valid, fpu_tag, fpu_out_ready, lsu_req_valid,
        input  fpr_we, fpr_waddr, fpr_wsel, xres_valid
    );
endinterface

// File: rtl/fpu_ss_scoreboard.sv
// fpu_ss_scoreboard: per-FP-register busy bits with one set port, two clear ports and four read ports.
module fpu_ss_scoreboard
    import fpu_ss_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  fpr_addr_t            set_addr,
    input  logic                 clr_fpu_en,
    input  fpr_addr_t            clr_fpu_addr,
    input  logic                 clr_mem_en,
    input  fpr_addr_t            clr_mem_addr,
    input  fpr_addr_t [2:0]      rs_addr,
    input  fpr_addr_t            rd_addr,
    output logic [2:0]           rs_hit,
    output logic                 rd_hit,
    output logic [NumFpRegs-1:0] busy
);
    logic [NumFpRegs-1:0] set_mask, clr_mask;
    always_comb begin
        set_mask = NumFpRegs'(set_en) << set_addr;
        clr_mask = (NumFpRegs'(clr_fpu_en) << clr_fpu_addr) | (NumFpRegs'(clr_mem_en) << clr_mem_addr);
        rd_hit   = busy[rd_addr];
    end
    for (genvar k = 0; k < 3; k++) begin : g_rs
        assign rs_hit[k] = busy[rs_addr[k]];
    end
    // set is applied after clear so a same-cycle collision leaves the register busy
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_mask) | set_mask;
    end
endmodule

// File: rtl/fpu_ss_issue_ctrl.sv
// fpu_ss_issue_ctrl: hazard-checked issue to fpnew/LSU and FP regfile writeback arbitration.
module fpu_ss_issue_ctrl
    import fpu_ss_pkg::*;
#(
    parameter  int MaxOutstanding = 4,
    localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_ss_issue_ctrl_if.slave   bus,
    output logic [NumFpRegs-1:0] busy,
    output logic [CntWidth-1:0]  outstanding
);
    logic [2:0] rs_hit;
    logic       rd_hit, hazard, full, mem_wr, fpu_fp_ret, inc, dec, set_en;
    fpu_ss_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .set_en       (set_en),
        .set_addr     (bus.issue_rd),
        .clr_fpu_en   (fpu_fp_ret),
        .clr_fpu_addr (bus.fpu_out_tag.addr),
        .clr_mem_en   (mem_wr),
        .clr_mem_addr (bus.mem_meta.rd),
        .rs_addr      (bus.issue_rs_addr),
        .rd_addr      (bus.issue_rd),
        .rs_hit       (rs_hit),
        .rd_hit       (rd_hit),
        .busy         (busy)
    );
    // a retiring result frees its slot in the same cycle, so a full queue can still accept
    always_comb begin
        hazard            = |(bus.issue_rs_fp & rs_hit) | (bus.issue_rd_is_fp & rd_hit);
        mem_wr            = !rst & bus.mem_res_valid & bus.mem_meta.we;
        bus.fpu_out_ready = !rst & bus.fpu_out_valid & (bus.fpu_out_tag.rd_is_fp ? !mem_wr : bus.xres_ready);
        bus.xres_valid    = !rst & bus.fpu_out_valid & !bus.fpu_out_tag.rd_is_fp;
        dec               = bus.fpu_out_ready;
        fpu_fp_ret        = dec & bus.fpu_out_tag.rd_is_fp;
        full              = (outstanding == CntWidth'(MaxOutstanding)) & !dec;
        bus.fpu_in_valid  = !rst & bus.issue_valid & !bus.issue_is_load & !hazard & !full;
        bus.lsu_req_valid = !rst & bus.issue_valid & bus.issue_is_load & !hazard;
        bus.fpu_tag       = '{addr: bus.issue_rd, rd_is_fp: bus.issue_rd_is_fp, id: bus.issue_id};
        inc               = bus.fpu_in_valid & bus.fpu_in_ready;
        bus.issue_ready   = inc | (bus.lsu_req_valid & bus.lsu_req_ready);
        set_en            = bus.issue_ready & bus.issue_rd_is_fp;
        bus.fpr_we        = mem_wr | fpu_fp_ret;
        bus.fpr_waddr     = mem_wr ? bus.mem_meta.rd : bus.fpu_out_tag.addr;
        bus.fpr_wsel      = mem_wr;
    end
    always_ff @(posedge clk) begin
        if (rst) outstanding <= '0;
        else     outstanding <= outstanding + CntWidth'(inc) - CntWidth'(dec);
    end
    a_cnt_max: assert property (@(posedge clk) disable iff (rst) outstanding <= CntWidth'(MaxOutstanding));
    a_cnt_min: assert property (@(posedge clk) disable iff (rst) !(dec && !inc && outstanding == '0));
    a_ld_busy: assert property (@(posedge clk) disable iff (rst) mem_wr |-> busy[bus.mem_meta.rd]);
    a_set_clr: assert property (@(posedge clk) disable iff (rst)
        !(set_en && ((fpu_fp_ret && bus.issue_rd == bus.fpu_out_tag.addr) || (mem_wr && bus.issue_rd == bus.mem_meta.rd))));
endmodule

// File: tb/tb_fpu_ss_issue_ctrl.sv
// tb_fpu_ss_issue_ctrl: directed vector table plus hand-written multi-cycle sequences.
module tb_fpu_ss_issue_ctrl;
    import fpu_ss_pkg::*;
    logic        clk = 0;
    logic        rst;
    logic [31:0] busy;
    logic [2:0]  outstanding;
    int          n_vec = 0;
    int          n_bad = 0;
    fpu_ss_issue_ctrl_if bus();
    fpu_ss_issue_ctrl #(.MaxOutstanding(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .outstanding (outstanding)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic iv, ld; logic [4:0] rs1, rs2; logic [2:0] rsfp; logic [4:0] rd; logic rdfp;
        logic fov; logic [4:0] frd; logic ffp; logic mv; logic [4:0] mrd;
        logic e_ir, e_fv, e_lv, e_we; logic [4:0] e_wa; logic e_ws, e_for; logic [31:0] e_busy; logic [2:0] e_cnt;
    } vec_t;
    vec_t tbl[12];
    function automatic vec_t mk(input logic iv, ld, input logic [4:0] rs1, rs2, input logic [2:0] rsfp,
                                input logic [4:0] rd, input logic rdfp, fov, input logic [4:0] frd,
                                input logic ffp, mv, input logic [4:0] mrd, input logic e_ir, e_fv, e_lv, e_we,
                                input logic [4:0] e_wa, input logic e_ws, e_for, input logic [31:0] e_busy,
                                input logic [2:0] e_cnt);
        return '{iv, ld, rs1, rs2, rsfp, rd, rdfp, fov, frd, ffp, mv, mrd,
                 e_ir, e_fv, e_lv, e_we, e_wa, e_ws, e_for, e_busy, e_cnt};
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic idle();
        bus.issue_valid = 0; bus.issue_is_load = 0; bus.issue_rs_addr = '0; bus.issue_rs_fp = 0;
        bus.issue_rd = 0; bus.issue_rd_is_fp = 0; bus.issue_id = 0;
        bus.fpu_in_ready = 1; bus.lsu_req_ready = 1; bus.xres_ready = 0;
        bus.fpu_out_valid = 0; bus.fpu_out_tag = '0; bus.mem_res_valid = 0; bus.mem_meta = '0;
    endtask
    task automatic issue(input logic ld, input logic [4:0] rs1, rs2, input logic [2:0] rsfp,
                         input logic [4:0] rd, input logic rdfp);
        bus.issue_valid = 1; bus.issue_is_load = ld; bus.issue_rs_addr = {5'd0, rs2, rs1};
        bus.issue_rs_fp = rsfp; bus.issue_rd = rd; bus.issue_rd_is_fp = rdfp;
    endtask
    task automatic result(input logic [4:0] frd, input logic ffp);
        bus.fpu_out_valid = 1; bus.fpu_out_tag = '{addr: frd, rd_is_fp: ffp, id: 4'd0};
    endtask
    task automatic load_ret(input logic [4:0] mrd);
        bus.mem_res_valid = 1; bus.mem_meta = '{id: 4'd0, rd: mrd, we: 1'b1};
    endtask
    task automatic step();
        @(posedge clk); #1;
        @(negedge clk);
    endtask
    initial begin
        tbl[0]  = mk(1,0, 0,0,3, 1,1, 0,0,0, 0,0, 1,1,0,0, 0,0,0, 32'h02, 1);
        tbl[1]  = mk(1,0, 0,0,3, 2,1, 0,0,0, 0,0, 1,1,0,0, 0,0,0, 32'h06, 2);
        tbl[2]  = mk(1,0, 0,0,3, 3,1, 0,0,0, 0,0, 1,1,0,0, 0,0,0, 32'h0E, 3);
        tbl[3]  = mk(1,0, 3,2,3, 4,1, 1,1,1, 0,0, 0,0,0,1, 1,0,1, 32'h0C, 2);
        tbl[4]  = mk(1,0, 3,2,3, 4,1, 1,2,1, 0,0, 0,0,0,1, 2,0,1, 32'h08, 1);
        tbl[5]  = mk(1,0, 3,2,3, 4,1, 1,3,1, 0,0, 0,0,0,1, 3,0,1, 32'h00, 0);
        tbl[6]  = mk(1,0, 3,2,3, 4,1, 0,0,0, 0,0, 1,1,0,0, 0,0,0, 32'h10, 1);
        tbl[7]  = mk(1,1, 0,0,0, 5,1, 0,0,0, 0,0, 1,0,1,0, 0,0,0, 32'h30, 1);
        tbl[8]  = mk(1,0, 0,0,3, 6,1, 0,0,0, 0,0, 1,1,0,0, 0,0,0, 32'h70, 2);
        tbl[9]  = mk(0,0, 0,0,0, 0,0, 1,6,1, 1,5, 0,0,0,1, 5,1,0, 32'h50, 2);
        tbl[10] = mk(0,0, 0,0,0, 0,0, 1,6,1, 0,0, 0,0,0,1, 6,0,1, 32'h10, 1);
        tbl[11] = mk(0,0, 0,0,0, 0,0, 1,4,1, 0,0, 0,0,0,1, 4,0,1, 32'h00, 0);
        idle();
        rst = 1;
        issue(0, 0, 0, 3, 1, 1);
        result(2, 1);
        #1;
        chk("rst_fpu_in_valid", bus.fpu_in_valid, 0);
        chk("rst_issue_ready", bus.issue_ready, 0);
        chk("rst_fpu_out_ready", bus.fpu_out_ready, 0);
        chk("rst_fpr_we", bus.fpr_we, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_cnt", outstanding, 0);
        @(negedge clk);
        rst = 0;
        idle();
        foreach (tbl[i]) begin
            idle();
            if (tbl[i].iv) issue(tbl[i].ld, tbl[i].rs1, tbl[i].rs2, tbl[i].rsfp, tbl[i].rd, tbl[i].rdfp);
            if (tbl[i].fov) result(tbl[i].frd, tbl[i].ffp);
            if (tbl[i].mv) load_ret(tbl[i].mrd);
            #1;
            chk($sformatf("v%0d_issue_ready", i), bus.issue_ready, tbl[i].e_ir);
            chk($sformatf("v%0d_fpu_in_valid", i), bus.fpu_in_valid, tbl[i].e_fv);
            chk($sformatf("v%0d_lsu_req_valid", i), bus.lsu_req_valid, tbl[i].e_lv);
            chk($sformatf("v%0d_fpr_we", i), bus.fpr_we, tbl[i].e_we);
            if (tbl[i].e_we) begin
                chk($sformatf("v%0d_fpr_waddr", i), bus.fpr_waddr, tbl[i].e_wa);
                chk($sformatf("v%0d_fpr_wsel", i), bus.fpr_wsel, tbl[i].e_ws);
            end
            chk($sformatf("v%0d_fpu_out_ready", i), bus.fpu_out_ready, tbl[i].e_for);
            @(posedge clk); #1;
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_cnt", i), outstanding, tbl[i].e_cnt);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            issue(0, 0, 0, 0, 5'(8 + i), 1);
            #1;
            chk("full_fill_ready", bus.issue_ready, 1);
            step();
        end
        idle();
        issue(0, 0, 0, 0, 12, 1);
        #1;
        chk("full_cnt", outstanding, 4);
        chk("full_stall_valid", bus.fpu_in_valid, 0);
        chk("full_stall_ready", bus.issue_ready, 0);
        step();
        result(8, 1);
        #1;
        chk("full_retire_fire", bus.issue_ready, 1);
        @(posedge clk); #1;
        chk("full_retire_cnt", outstanding, 4);
        chk("full_retire_busy", busy, 32'h1E00);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            idle();
            result(5'(9 + i), 1);
            step();
        end
        chk("full_drain_cnt", outstanding, 0);
        chk("full_drain_busy", busy, 0);
        idle();
        issue(0, 0, 0, 3, 5, 0);
        step();
        chk("xres_issue_cnt", outstanding, 1);
        chk("xres_issue_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            result(5, 0);
            bus.xres_ready = (i == 3);
            #1;
            chk("xres_valid", bus.xres_valid, 1);
            chk("xres_fpu_out_ready", bus.fpu_out_ready, i == 3);
            chk("xres_fpr_we", bus.fpr_we, 0);
            @(posedge clk); #1;
            chk("xres_cnt", outstanding, (i == 3) ? 3'd0 : 3'd1);
            @(negedge clk);
        end
        idle(); issue(1, 0, 0, 0, 5, 1); step();
        idle(); issue(0, 0, 0, 3, 4, 1); step();
        idle(); issue(0, 0, 0, 3, 1, 0); step();
        idle(); issue(0, 0, 0, 3, 2, 0); step();
        chk("pre_rst_busy", busy, 32'h30);
        chk("pre_rst_cnt", outstanding, 3);
        idle();
        rst = 1;
        issue(0, 0, 0, 0, 7, 1);
        result(4, 1);
        load_ret(5);
        #1;
        chk("mid_rst_fpu_in_valid", bus.fpu_in_valid, 0);
        chk("mid_rst_lsu_req_valid", bus.lsu_req_valid, 0);
        chk("mid_rst_fpr_we", bus.fpr_we, 0);
        chk("mid_rst_xres_valid", bus.xres_valid, 0);
        chk("mid_rst_fpu_out_ready", bus.fpu_out_ready, 0);
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", outstanding, 0);
        @(negedge clk);
        rst = 0;
        idle();
        issue(0, 0, 0, 3, 7, 1);
        #1;
        chk("post_rst_issue", bus.issue_ready, 1);
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 32'h80);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
